// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, baud divisors,
// frame constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int FRAME_BITS = 11;
    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick at 50 MHz with 16x oversampling.
    function automatic logic [13:0] baud_divisor(input logic [2:0] sel);
        logic [13:0] div;
        case (sel)
            3'b000:  div = 14'd10417;
            3'b001:  div = 14'd2604;
            3'b010:  div = 14'd651;
            3'b011:  div = 14'd326;
            3'b100:  div = 14'd163;
            3'b101:  div = 14'd81;
            3'b110:  div = 14'd54;
            default: div = 14'd27;
        endcase
        return div;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_tick_gen.sv
// Restartable clock divider producing a one-cycle tick every 'divisor' clocks
// while enabled.
module uart_tx_tick_gen
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    input  logic [13:0] divisor,
    output logic        tick
);

    logic [13:0] cnt_q;
    logic [13:0] cnt_d;
    logic        last;

    assign last = (cnt_q == (divisor - 14'd1));
    assign tick = enable && !restart && last;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = 14'd0;
        end else if (enable) begin
            cnt_d = last ? 14'd0 : cnt_q + 14'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 14'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop; each bit
// lasts 16 divider ticks. TxD and Tx_BUSY are registered from the next state.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int SIM_DIV = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    output logic       TxD,
    output logic       Tx_BUSY
);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [2:0]  baud_q, baud_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        tick;
    logic        bit_done;
    logic [13:0] divisor;

    assign accept   = Tx_WR && Tx_EN && !busy_q;
    assign divisor  = (SIM_DIV != 0) ? 14'(SIM_DIV) : baud_divisor(baud_q);
    assign bit_done = tick && (tick_cnt_q == 4'(OVERSAMPLE - 1));

    uart_tx_tick_gen u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q != ST_IDLE),
        .restart (accept),
        .divisor (divisor),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        baud_d     = baud_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;

        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d    = ST_START;
                shift_d    = Tx_DATA;
                parity_d   = even_parity(Tx_DATA);
                baud_d     = baud_select;
                tick_cnt_d = 4'd0;
                bit_idx_d  = 3'd0;
            end
        end else if (tick) begin
            // The 4-bit tick counter wraps to 0 exactly at each bit boundary.
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (bit_done) begin
                unique case (state_q)
                    ST_START: begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                    ST_DATA: begin
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                    ST_PARITY: state_d = ST_STOP;
                    ST_STOP:   state_d = ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end
        end

        txd_d  = 1'b1;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = parity_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            baud_q     <= 3'd0;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            baud_q     <= baud_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: one fast-divider instance and one using
// the real baud table, with a byte scoreboard checked against decoded frames.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       wr_fast;
    logic       wr_real;
    logic [7:0] tx_data;
    logic [2:0] baud;
    logic       txd_fast, busy_fast;
    logic       txd_real, busy_real;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    uart_transmitter #(.SIM_DIV(1)) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (tx_data),
        .baud_select (baud),
        .Tx_EN       (tx_en),
        .Tx_WR       (wr_fast),
        .TxD         (txd_fast),
        .Tx_BUSY     (busy_fast)
    );

    uart_transmitter #(.SIM_DIV(0)) dut_real (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (tx_data),
        .baud_select (baud),
        .Tx_EN       (tx_en),
        .Tx_WR       (wr_real),
        .TxD         (txd_real),
        .Tx_BUSY     (busy_real)
    );

    function automatic logic cur_txd(input bit sel);
        return sel ? txd_real : txd_fast;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy_real : busy_fast;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle write strobe from a negedge; returns at the next negedge.
    task automatic applyStimulus(input bit sel, input logic [7:0] d, input logic [2:0] b, input bit push);
        tx_data = d;
        baud    = b;
        if (sel) wr_real = 1'b1;
        else     wr_fast = 1'b1;
        if (push) sb_q.push_back(d);
        @(negedge clk);
        wr_real = 1'b0;
        wr_fast = 1'b0;
    endtask

    // Follow one whole frame cycle by cycle. action 1 pulses an ignored write of
    // 0x01 at action_cycle; action 2 drops Tx_EN at action_cycle.
    task automatic checkFrame(input string tag, input bit sel, input int d, input int exp_wait,
                              input int action, input int action_cycle);
        logic [7:0]  exp_byte;
        logic [10:0] exp_bits;
        logic [10:0] rx_bits;
        int          bit_len;
        int          waited;
        int          bit_err;
        int          busy_err;
        int          c;
        bit_len  = 16 * d;
        waited   = 0;
        busy_err = 0;
        rx_bits  = '0;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
            return;
        end
        exp_byte = sb_q.pop_front();
        exp_bits = {1'b1, ^exp_byte, exp_byte, 1'b0};
        while (cur_txd(sel) !== 1'b0 && waited <= 8) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_start_wait"}, 32'(waited), 32'(exp_wait));
        if (waited > 8) return;
        for (int b = 0; b < 11; b++) begin
            bit_err = 0;
            for (int k = 0; k < bit_len; k++) begin
                c = b * bit_len + k;
                if (action == 1 && c == action_cycle) begin
                    tx_data = 8'h01;
                    if (sel) wr_real = 1'b1;
                    else     wr_fast = 1'b1;
                end
                if (action == 1 && c == action_cycle + 1) begin
                    wr_real = 1'b0;
                    wr_fast = 1'b0;
                end
                if (action == 2 && c == action_cycle) tx_en = 1'b0;
                if (cur_txd(sel) !== exp_bits[b]) bit_err++;
                if (cur_busy(sel) !== 1'b1) busy_err++;
                if (k == bit_len / 2) rx_bits[b] = cur_txd(sel);
                @(negedge clk);
            end
            checkOutput($sformatf("%s_bit%0d_errors", tag, b), 32'(bit_err), 32'd0);
        end
        checkOutput({tag, "_rx_byte"}, 32'(rx_bits[8:1]), 32'(exp_byte));
        checkOutput({tag, "_rx_parity"}, 32'(rx_bits[9]), 32'(^exp_byte));
        checkOutput({tag, "_busy_low_cycles"}, 32'(busy_err), 32'd0);
        checkOutput({tag, "_busy_fall"}, 32'(cur_busy(sel)), 32'd0);
        checkOutput({tag, "_idle_txd"}, 32'(cur_txd(sel)), 32'd1);
    endtask

    // Watch the fast line for n cycles and require it to stay idle.
    task automatic checkIdle(input string tag, input int n);
        int err;
        err = 0;
        for (int i = 0; i < n; i++) begin
            if (txd_fast !== 1'b1 || busy_fast !== 1'b0) err++;
            @(negedge clk);
        end
        checkOutput(tag, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        tx_en   = 1'b1;
        wr_fast = 1'b0;
        wr_real = 1'b0;
        tx_data = 8'h00;
        baud    = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd_fast", 32'(txd_fast), 32'd1);
        checkOutput("reset_busy_fast", 32'(busy_fast), 32'd0);
        checkOutput("reset_txd_real", 32'(txd_real), 32'd1);
        checkOutput("reset_busy_real", 32'(busy_real), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_txd", 32'(txd_fast), 32'd1);

        $display("[TB] 0xA5 frame with an ignored write while busy");
        applyStimulus(1'b0, 8'hA5, 3'b000, 1'b1);
        checkFrame("a5", 1'b0, 1, 0, 1, 40);

        $display("[TB] back-to-back write of 0x01 as busy falls");
        applyStimulus(1'b0, 8'h01, 3'b000, 1'b1);
        checkFrame("b2b_01", 1'b0, 1, 0, 0, 0);
        checkIdle("no_extra_frame", 40);

        $display("[TB] write with Tx_EN low");
        tx_en = 1'b0;
        applyStimulus(1'b0, 8'h77, 3'b000, 1'b0);
        checkIdle("en_low_write", 30);
        tx_en = 1'b1;

        $display("[TB] Tx_EN dropped mid-frame");
        applyStimulus(1'b0, 8'hC3, 3'b000, 1'b1);
        checkFrame("en_drop_c3", 1'b0, 1, 0, 2, 50);
        tx_en = 1'b1;

        $display("[TB] real baud table at 115200, inputs changed mid-frame");
        applyStimulus(1'b1, 8'h3C, 3'b111, 1'b1);
        tx_data = 8'h00;
        baud    = 3'b000;
        checkFrame("real_3c", 1'b1, 27, 0, 0, 0);

        $display("[TB] asynchronous reset during data bit 4");
        applyStimulus(1'b0, 8'h0F, 3'b000, 1'b0);
        repeat (88) @(negedge clk);
        checkOutput("pre_reset_d4", 32'(txd_fast), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_txd", 32'(txd_fast), 32'd1);
        checkOutput("async_reset_busy", 32'(busy_fast), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_txd", 32'(txd_fast), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_release_txd", 32'(txd_fast), 32'd1);
        checkOutput("reset_release_busy", 32'(busy_fast), 32'd0);
        applyStimulus(1'b0, 8'hFF, 3'b000, 1'b1);
        checkFrame("after_reset_ff", 1'b0, 1, 0, 0, 0);

        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
